// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds default geometry, the architectural register address type and the
// highest-lane-wins write select used by both storage and read bypass.
package reg_file_pkg;

    localparam int DEFAULT_DEPTH = 32;
    localparam int DEFAULT_WIDTH = 32;
    // Widest write-lane count supported; lane index fits in one bit.
    localparam int MAX_WR        = 2;

    typedef logic [$clog2(DEFAULT_DEPTH)-1:0] reg_addr_t;

    typedef struct packed {
        logic hit;   // some enabled lane targets this address
        logic lane;  // winning lane index
    } wr_sel_t;

    // match[w] = lane w is enabled and addresses the register of interest.
    // Scanning upward lets the highest-numbered matching lane overwrite
    // earlier ones, so the younger writeback lane wins a same-address tie.
    function automatic wr_sel_t wr_select(input logic [MAX_WR-1:0] match);
        wr_sel_t sel;
        sel = '0;
        for (int w = 0; w < MAX_WR; w++) begin
            if (match[w]) begin
                sel.hit  = 1'b1;
                sel.lane = 1'(w);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Purpose: per-register pending-write (busy) vector with flush > issue-set > write-clear priority.
// Latency: busy and busy_any update one edge after the issue/write/flush that changes them.
// Backpressure: none; every issue, write and flush is accepted in the cycle presented.
// Ports: clk, reset (async, active-high); iss_valid/iss_rd set a bit; wr_en/wr_addr
//        (NUM_WR lanes, flat) clear bits; flush clears all; busy is the raw vector,
//        busy_any the registered OR of it.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 flush,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    output logic [DEPTH-1:0]     busy,
    output logic                 busy_any
);

    logic [DEPTH-1:0] busy_nxt;

    // Applied lowest priority first so later statements override: a retiring
    // write clears, a same-cycle issue to that register (younger) re-sets it,
    // and a flush discards everything including that issue.
    always_comb begin
        busy_nxt = busy;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
                busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (iss_valid && !(ZERO_REG != 0 && iss_rd == '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
    end

    // busy_any is its own flop so it is a clean registered summary rather
    // than a DEPTH-wide OR tree hanging off the busy vector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_any <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_any <= |busy_nxt;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Purpose: multi-port integer register file with pending-write scoreboard (operand fetch + writeback).
// Latency: writes visible the cycle after the edge; reads combinational; optional same-cycle bypass.
// Backpressure: none; all writes, issues and reads are serviced every cycle.
// Ports: clk, reset (async, active-high); wr_en/wr_addr/wr_data per write lane (flat vectors);
//        rd_addr -> rd_data/rd_busy per read port; iss_valid/iss_rd mark a destination busy;
//        flush clears busy bits; busy_any is the registered OR of all busy bits.
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_WR-1:0]       wr_en,
    input  logic [NUM_WR*AW-1:0]    wr_addr,
    input  logic [NUM_WR*WIDTH-1:0] wr_data,
    input  logic [NUM_RD*AW-1:0]    rd_addr,
    output logic [NUM_RD*WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]       rd_busy,
    input  logic                    iss_valid,
    input  logic [AW-1:0]           iss_rd,
    input  logic                    flush,
    output logic                    busy_any
);

    logic [WIDTH-1:0]  regs      [DEPTH];
    logic [DEPTH-1:0]  busy;

    // Lanes padded out to MAX_WR so the shared select function always sees a
    // fixed-width match vector; absent lanes are permanently disabled.
    logic [MAX_WR-1:0] lane_en;
    logic [AW-1:0]     lane_addr [MAX_WR];
    logic [WIDTH-1:0]  lane_data [MAX_WR];

    for (genvar w = 0; w < MAX_WR; w++) begin : g_lane
        if (w < NUM_WR) begin : g_used
            assign lane_en[w]   = wr_en[w];
            assign lane_addr[w] = wr_addr[w*AW +: AW];
            assign lane_data[w] = wr_data[w*WIDTH +: WIDTH];
        end else begin : g_unused
            assign lane_en[w]   = 1'b0;
            assign lane_addr[w] = '0;
            assign lane_data[w] = '0;
        end
    end

    // Per-register winning write lane.
    wr_sel_t reg_sel [DEPTH];

    always_comb begin
        logic [MAX_WR-1:0] m;
        for (int r = 0; r < DEPTH; r++) begin
            m = '0;
            for (int w = 0; w < MAX_WR; w++) begin
                m[w] = lane_en[w] && (lane_addr[w] == AW'(r));
            end
            reg_sel[r] = wr_select(m);
        end
    end

    // Writes commit even during flush; only the scoreboard reacts to flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                if (reg_sel[r].hit && !(ZERO_REG != 0 && r == 0)) begin
                    regs[r] <= lane_data[reg_sel[r].lane];
                end
            end
        end
    end

    reg_scoreboard #(
        .DEPTH    (DEPTH),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .reset     (reset),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .flush     (flush),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .busy_any  (busy_any)
    );

    always_comb begin
        logic [AW-1:0]     a;
        logic [WIDTH-1:0]  d;
        logic              b;
`ifdef REG_FILE_BYPASS_EN
        logic [MAX_WR-1:0] m;
        wr_sel_t           s;
`endif
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            a = rd_addr[i*AW +: AW];
            d = regs[a];
            b = busy[a];
            if (ZERO_REG != 0 && a == '0) begin
                d = '0;
            end
`ifdef REG_FILE_BYPASS_EN
            // Forwarded result is delivered now, so the operand is no longer
            // pending. Gated by reset so reads stay zero while reset is held.
            m = '0;
            for (int w = 0; w < MAX_WR; w++) begin
                m[w] = lane_en[w] && (lane_addr[w] == a);
            end
            s = wr_select(m);
            if (s.hit && !reset && !(ZERO_REG != 0 && a == '0)) begin
                d = lane_data[s.lane];
                b = 1'b0;
            end
`endif
            rd_data[i*WIDTH +: WIDTH] = d;
            rd_busy[i]                = b;
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int AW = 5;
    localparam int W  = 32;
    localparam int NR = 2;
    localparam int NW = 2;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NW-1:0]   wr_en = '0;
    logic [NW*AW-1:0] wr_addr = '0;
    logic [NW*W-1:0] wr_data = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*W-1:0] rd_data;
    logic [NR-1:0]   rd_busy;
    logic            iss_valid = 1'b0;
    logic [AW-1:0]   iss_rd = '0;
    logic            flush = 1'b0;
    logic            busy_any;

    always #5 clk = ~clk;

    reg_file_mp #(
        .DEPTH(32), .WIDTH(W), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush),
        .busy_any(busy_any)
    );

    // Reference model: architectural contents and pending set.
    logic [W-1:0] m_reg [32];
    logic [31:0]  m_busy;

    typedef struct {
        string        tag;
        logic [W-1:0] d0;
        logic [W-1:0] d1;
        logic         b0;
        logic         b1;
        logic         ba;
    } exp_t;

    exp_t exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
        m_busy = '0;
    endtask

    // Expected read-port view for the inputs currently driven.
    function automatic exp_t predict(input string tag);
        exp_t e;
        logic [W-1:0] d [NR];
        logic         b [NR];
        logic [AW-1:0] a;
        for (int i = 0; i < NR; i++) begin
            a    = rd_addr[i*AW +: AW];
            d[i] = (a == 0) ? '0 : m_reg[a];
            b[i] = m_busy[a];
`ifdef REG_FILE_BYPASS_EN
            for (int w = 0; w < NW; w++) begin
                if (wr_en[w] && wr_addr[w*AW +: AW] == a && a != 0) begin
                    d[i] = wr_data[w*W +: W];
                    b[i] = 1'b0;
                end
            end
`endif
            if (reset) begin
                d[i] = '0;
                b[i] = 1'b0;
            end
        end
        e.tag = tag;
        e.d0  = d[0];
        e.d1  = d[1];
        e.b0  = b[0];
        e.b1  = b[1];
        e.ba  = reset ? 1'b0 : (m_busy != 0);
        return e;
    endfunction

    // Effect of one clock edge on the architectural state.
    task automatic model_commit();
        logic [AW-1:0] wa;
        logic          cleared [32];
        for (int r = 0; r < 32; r++) cleared[r] = 1'b0;
        for (int w = 0; w < NW; w++) begin
            wa = wr_addr[w*AW +: AW];
            if (wr_en[w]) begin
                cleared[wa] = 1'b1;
                if (wa != 0) m_reg[wa] = wr_data[w*W +: W];
            end
        end
        for (int r = 0; r < 32; r++) begin
            if (flush)                                  m_busy[r] = 1'b0;
            else if (iss_valid && iss_rd == r && r != 0) m_busy[r] = 1'b1;
            else if (cleared[r])                        m_busy[r] = 1'b0;
        end
    endtask

    task automatic step(input string tag, input logic [1:0] we,
                        input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [W-1:0] wd0, input logic [W-1:0] wd1,
                        input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic iv, input logic [AW-1:0] ir, input logic fl);
        wr_en     = we;
        wr_addr   = {wa1, wa0};
        wr_data   = {wd1, wd0};
        rd_addr   = {ra1, ra0};
        iss_valid = iv;
        iss_rd    = ir;
        flush     = fl;
        exp_q.push_back(predict(tag));
        @(posedge clk);
        if (!reset) model_commit();
        #1;
    endtask

    task automatic read(input string tag, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        step(tag, 2'b00, 5'd0, 5'd0, '0, '0, ra0, ra1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic issue(input string tag, input logic [AW-1:0] ir);
        step(tag, 2'b00, 5'd0, 5'd0, '0, '0, ir, 5'd0, 1'b1, ir, 1'b0);
    endtask

    // Monitor: every falling edge, compare the DUT against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk({e.tag, ".rd0"},   rd_data[W-1:0],  e.d0);
            chk({e.tag, ".rd1"},   rd_data[2*W-1:W], e.d1);
            chk({e.tag, ".busy0"}, 32'(rd_busy[0]), 32'(e.b0));
            chk({e.tag, ".busy1"}, 32'(rd_busy[1]), 32'(e.b1));
            chk({e.tag, ".bany"},  32'(busy_any),   32'(e.ba));
        end
    end

    initial begin
        logic [1:0]    we;
        logic [AW-1:0] wa0, wa1, ra0, ra1, ir;
        logic [W-1:0]  wd0, wd1;
        logic          iv, fl;

        model_reset();
        @(posedge clk);
        #1;
        // Write attempted while reset is held must be discarded.
        step("in_reset", 2'b01, 5'd5, 5'd0, 32'h1111_2222, '0, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0);
        reset = 1'b0;
        read("post_reset", 5'd5, 5'd0);

        // Asynchronous reset mid-cycle.
        step("rst_wr", 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, '0, 5'd5, 5'd6, 1'b1, 5'd6, 1'b0);
        read("rst_pre", 5'd5, 5'd6);
        wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'h0, 32'h0BAD_0BAD};
        iss_valid = 1'b1; iss_rd = 5'd7; flush = 1'b0; rd_addr = {5'd6, 5'd5};
        #2;
        reset = 1'b1;
        model_reset();
        exp_q.push_back(predict("rst_async"));
        @(posedge clk);
        #1;
        reset = 1'b0;
        read("rst_after", 5'd5, 5'd7);

        // Register 0 protection.
        step("x0_wr", 2'b01, 5'd0, 5'd0, 32'h1234, '0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0);
        read("x0_rd", 5'd0, 5'd0);

        // Two lanes to one address: higher lane wins.
        step("prio_wr", 2'b11, 5'd7, 5'd7, 32'h11, 32'h22, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
        read("prio_rd", 5'd7, 5'd7);

        // Set/clear collision: issue wins over retiring write.
        issue("sb_iss", 5'd3);
        read("sb_busy", 5'd3, 5'd0);
        step("sb_coll", 2'b01, 5'd3, 5'd0, 32'h55, '0, 5'd3, 5'd0, 1'b1, 5'd3, 1'b0);
        read("sb_after", 5'd3, 5'd3);

        // Flush dominates a same-cycle issue.
        issue("fl_i1", 5'd1);
        issue("fl_i2", 5'd2);
        issue("fl_i9", 5'd9);
        read("fl_pre", 5'd1, 5'd9);
        step("fl_do", 2'b00, 5'd0, 5'd0, '0, '0, 5'd4, 5'd2, 1'b1, 5'd4, 1'b1);
        read("fl_post", 5'd4, 5'd1);

        // Same-cycle write/read of one register.
        step("byp_wr", 2'b01, 5'd10, 5'd0, 32'hA5A5, '0, 5'd10, 5'd10, 1'b1, 5'd10, 1'b0);
        step("byp_clr", 2'b10, 5'd0, 5'd10, '0, 32'h5A5A, 5'd10, 5'd0, 1'b0, 5'd0, 1'b0);
        read("byp_next", 5'd10, 5'd10);

        // Randomized traffic, reads biased toward the addresses being written.
        for (int n = 0; n < 400; n++) begin
            we  = 2'($urandom_range(0, 3));
            wa0 = 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            ra0 = ($urandom_range(0, 1) == 0) ? wa0 : 5'($urandom_range(0, 31));
            ra1 = ($urandom_range(0, 1) == 0) ? wa1 : 5'($urandom_range(0, 31));
            iv  = 1'($urandom_range(0, 1));
            ir  = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            fl  = ($urandom_range(0, 19) == 0);
            step("rand", we, wa0, wa1, wd0, wd1, ra0, ra1, iv, ir, fl);
        end
        read("final", 5'd1, 5'd31);

        repeat (3) @(posedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
